// File: rtl/spi_arbiter_ctrl.sv
// Two-requester SPI master: picks a winner, shifts one byte LSB-first on MOSI/MISO, pulses its done.
// Define SPI_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins a tie.
//
// state | meaning
// IDLE  | waiting for req0/req1, arbitrate and latch winner's tx/sel/id
// SETUP | CS low, SCLK low, MOSI = bit 0, one half-period
// HIGH  | SCLK high, one half-period; MISO sampled on exit
// LOW   | SCLK low, one half-period; MOSI advances on exit unless 8 bits done
// HOLD  | CS still low after the last bit, one half-period
// DONE  | CS released, rx_data updated, done pulse for one cycle
module spi_arbiter_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic [7:0] tx0,
  input  logic [7:0] tx1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCLK,
  output logic [3:0] CS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] bit_cnt;
  logic [6:0] tx_sh;
  logic [7:0] rx_sh;
  logic       id;
  logic       win;
  logic [1:0] sel_win;
  logic [7:0] tx_win;

`ifdef SPI_ARB_RR_EN
  logic prio1;

  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = prio1;
    else              win = req1;
  end
`else
  always_comb begin
    win = 1'b0;
    if (!req0) win = 1'b1;
  end
`endif

  always_comb begin
    sel_win = win ? sel1 : sel0;
    tx_win  = win ? tx1  : tx0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 4'd0;
      tx_sh   <= 7'd0;
      rx_sh   <= 8'd0;
      id      <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rx_data <= 8'h00;
      busy    <= 1'b0;
      SCLK    <= 1'b0;
      CS      <= 4'b1111;
      MOSI    <= 1'b0;
`ifdef SPI_ARB_RR_EN
      prio1   <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= SETUP;
            cnt     <= HALF_LOAD;
            bit_cnt <= 4'd0;
            id      <= win;
            tx_sh   <= tx_win[7:1];
            MOSI    <= tx_win[0];
            CS      <= ~(4'b0001 << sel_win);
            SCLK    <= 1'b0;
            busy    <= 1'b1;
`ifdef SPI_ARB_RR_EN
            prio1   <= ~win;
`endif
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= HIGH;
            SCLK  <= 1'b1;
            cnt   <= HALF_LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HIGH: begin
          if (cnt == 8'd0) begin
            state   <= LOW;
            SCLK    <= 1'b0;
            rx_sh   <= {MISO, rx_sh[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            cnt     <= HALF_LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOW: begin
          if (cnt == 8'd0) begin
            cnt <= HALF_LOAD;
            // Eight falling edges seen: finish with a hold period instead of another pulse.
            if (bit_cnt == 4'd8) begin
              state <= HOLD;
            end else begin
              state <= HIGH;
              SCLK  <= 1'b1;
              MOSI  <= tx_sh[0];
              tx_sh <= {1'b0, tx_sh[6:1]};
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state   <= DONE;
            CS      <= 4'b1111;
            rx_data <= rx_sh;
            done0   <= ~id;
            done1   <= id;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          CS    <= 4'b1111;
          SCLK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter_ctrl.sv
// Scoreboard bench for spi_arbiter_ctrl: directed transfers push expected results, a monitor checks each done.
// Honors SPI_ARB_RR_EN for the tie-order expectations.
module tb_spi_arbiter_ctrl;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] sel0 = 2'd0, sel1 = 2'd0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic       done0, done1, busy, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [3:0] cs;

  always #5 clk = ~clk;

  spi_arbiter_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .sel0(sel0), .sel1(sel1), .tx0(tx0), .tx1(tx1),
    .done0(done0), .done1(done1), .rx_data(rx_data), .busy(busy),
    .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [3:0] cs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [7:0] tx, input logic [7:0] rx,
                              input logic [3:0] c);
    exp_t e;
    e.id = id; e.tx = tx; e.rx = rx; e.cs = c;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Slave model and output monitor
  logic [7:0] slave_byte = 8'h00;
  int         sidx = 0;
  logic       sclk_q = 1'b0, busy_q = 1'b0;
  logic [3:0] cs_q = 4'hF, cs_seen = 4'hF;
  logic [7:0] mbyte = 8'h00;
  int         pulses = 0, busy_start = 0, gap = 0;
  logic       had_xfer = 1'b0;
  logic [7:0] sidx_b;

  always_comb begin
    sidx_b = slave_byte;
    miso = sidx_b[sidx[2:0]];
  end

  always @(negedge clk) begin
    exp_t e;
    if (&cs) sidx = 0;
    else if (sclk_q && !sclk) sidx++;

    if (!busy) begin
      pulses = 0; mbyte = 8'h00; cs_seen = 4'hF;
    end else begin
      if (!busy_q) busy_start = cyc;
      if (sclk && !sclk_q) pulses++;
      if (!sclk && sclk_q) begin
        mbyte = {mosi, mbyte[7:1]};
        cs_seen = cs;
      end
    end

    if (!(&cs) && (&cs_q)) begin
      if (had_xfer) check("cs_gap_ge2", gap >= 2, 1);
      gap = 0;
      had_xfer = 1'b1;
    end else if (&cs) begin
      gap++;
    end

    if (done0 || done1) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual done0=%0b done1=%0b required no pulse", done0, done1);
      end else begin
        e = sb.pop_front();
        check("done_onehot", done0 ^ done1, 1);
        check("winner_id", done1, e.id);
        check("rx_data", rx_data, e.rx);
        check("mosi_byte", mbyte, e.tx);
        check("cs_during", cs_seen, e.cs);
        check("sclk_pulses", pulses, 8);
        check("busy_to_done", cyc - busy_start, 18 * D);
      end
    end
    sclk_q = sclk; busy_q = busy; cs_q = cs;
  end

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy) return;
    end
    check("wait_busy_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int c = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done0 || done1) c++;
      if (c == n) return;
    end
    check("wait_dones_timeout", c, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 4'hF);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_rx", rx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Single transfer with latency check
    slave_byte = 8'h3C; sel0 = 2'd2; tx0 = 8'hA5;
    sb.push_back(mk(1'b0, 8'hA5, 8'h3C, 4'b1011));
    t0 = cyc;
    req0 = 1'b1;
    wait_busy(10);
    req0 = 1'b0;
    wait_idle(200);
    check("latency", last_done_cyc - t0, 18 * D + 1);

    // Inputs changed after accept are ignored
    slave_byte = 8'hC3; sel0 = 2'd1; tx0 = 8'h5A;
    sb.push_back(mk(1'b0, 8'h5A, 8'hC3, 4'b1101));
    req0 = 1'b1;
    wait_busy(10);
    tx0 = 8'hFF; sel0 = 2'd3; req0 = 1'b0;
    wait_idle(200);

    // Tie held for three transfers
    slave_byte = 8'h96; sel0 = 2'd0; sel1 = 2'd3; tx0 = 8'h11; tx1 = 8'h22;
`ifdef SPI_ARB_RR_EN
    sb.push_back(mk(1'b0, 8'h11, 8'h96, 4'b1110));
    sb.push_back(mk(1'b1, 8'h22, 8'h96, 4'b0111));
    sb.push_back(mk(1'b0, 8'h11, 8'h96, 4'b1110));
`else
    sb.push_back(mk(1'b0, 8'h11, 8'h96, 4'b1110));
    sb.push_back(mk(1'b0, 8'h11, 8'h96, 4'b1110));
    sb.push_back(mk(1'b0, 8'h11, 8'h96, 4'b1110));
`endif
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(3, 400);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(200);

    // Back-to-back from a held level request
    slave_byte = 8'h81; sel1 = 2'd1; tx1 = 8'h3E;
    repeat (3) sb.push_back(mk(1'b1, 8'h3E, 8'h81, 4'b1101));
    req1 = 1'b1;
    wait_dones(3, 400);
    req1 = 1'b0;
    wait_idle(200);

    // Reset at cycle 10 of a transfer
    sel0 = 2'd3; tx0 = 8'h77; slave_byte = 8'hEE;
    req0 = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("abort_cs", cs, 4'hF);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", {done1, done0}, 0);
    check("abort_mosi", mosi, 0);
    check("abort_rx", rx_data, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // New request accepted after reset release
    slave_byte = 8'h5A; sel0 = 2'd2; tx0 = 8'hC9;
    sb.push_back(mk(1'b0, 8'hC9, 8'h5A, 4'b1011));
    req0 = 1'b1;
    wait_busy(10);
    req0 = 1'b0;
    wait_idle(200);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
